// File: rtl/rv_iommu_pdt_walk.sv
// Process-context fetch engine: PDTC lookup, then on a miss a PD20/PD17/PD8 walk,
// leaf PC validation, PDTC fill and response. One request in flight.
module rv_iommu_pdt_walk #(
  parameter int unsigned MAX_PPN = 34,
  parameter int unsigned MAX_PA  = 46
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [23:0]        req_device_id_i,
  input  logic [19:0]        req_process_id_i,
  input  logic [3:0]         pdtp_mode_i,
  input  logic [MAX_PPN-1:0] pdtp_ppn_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic               rsp_fault_o,
  output logic [11:0]        rsp_cause_o,
  output logic               rsp_ens_o,
  output logic               rsp_sum_o,
  output logic [19:0]        rsp_pscid_o,
  output logic [3:0]         rsp_fsc_mode_o,
  output logic [MAX_PPN-1:0] rsp_fsc_ppn_o,
  output logic               pdtc_lookup_o,
  output logic               pdtc_fill_o,
  output logic [23:0]        pdtc_device_id_o,
  output logic [19:0]        pdtc_process_id_o,
  output logic               pdtc_ens_o,
  output logic               pdtc_sum_o,
  output logic [19:0]        pdtc_pscid_o,
  output logic [3:0]         pdtc_fsc_mode_o,
  output logic [MAX_PPN-1:0] pdtc_fsc_ppn_o,
  input  logic               pdtc_lkup_fill_done_i,
  input  logic               pdtc_hit_i,
  input  logic               pdtc_ens_i,
  input  logic               pdtc_sum_i,
  input  logic [19:0]        pdtc_pscid_i,
  input  logic [3:0]         pdtc_fsc_mode_i,
  input  logic [MAX_PPN-1:0] pdtc_fsc_ppn_i,
  output logic               mem_req_o,
  output logic [MAX_PA-1:0]  mem_addr_o,
  input  logic               mem_gnt_i,
  input  logic               mem_rvalid_i,
  input  logic [63:0]        mem_rdata_i,
  input  logic               mem_err_i
);

  localparam logic [11:0] CAUSE_TTYP = 12'd260;
  localparam logic [11:0] CAUSE_LDF  = 12'd265;
  localparam logic [11:0] CAUSE_INV  = 12'd266;
  localparam logic [11:0] CAUSE_MCFG = 12'd267;

  localparam logic [3:0] MODE_PD8  = 4'd1;
  localparam logic [3:0] MODE_PD17 = 4'd2;
  localparam logic [3:0] MODE_PD20 = 4'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_RD_REQ, S_RD_WAIT, S_FILL, S_RSP
  } state_t;

  state_t             state;
  logic [1:0]         level_q;
  logic               leaf_fsc_q;
  logic [MAX_PPN-1:0] ppn_q;

  logic               pid_ok_c;
  logic               rd_fault_c;
  logic [11:0]        rd_cause_c;
  logic [43:0]        nl_ppn_full_c;
  logic               nl_ppn_hi_c;
  logic               fsc_ppn_hi_c;
  logic               fsc_mode_ok_c;
  logic [MAX_PPN-1:0] nl_ppn_c;

  // Table entry address for a given level; leaf PCs are 16 bytes, non-leaf entries 8.
  function automatic logic [MAX_PA-1:0] walk_addr(input logic [MAX_PPN-1:0] ppn,
                                                  input logic [1:0] lvl,
                                                  input logic [19:0] pid);
    logic [MAX_PA-1:0] base;
    base = {ppn, 12'h000};
    case (lvl)
      2'd2:    return base + MAX_PA'({pid[19:17], 3'b000});
      2'd1:    return base + MAX_PA'({pid[16:8], 3'b000});
      default: return base + MAX_PA'({pid[7:0], 4'b0000});
    endcase
  endfunction

  // PID must fit the table depth selected by the PDT mode.
  always_comb begin
    pid_ok_c = 1'b0;
    case (pdtp_mode_i)
      MODE_PD8:  pid_ok_c = (req_process_id_i[19:8] == 12'd0);
      MODE_PD17: pid_ok_c = (req_process_id_i[19:17] == 3'd0);
      MODE_PD20: pid_ok_c = 1'b1;
      default:   pid_ok_c = 1'b0;
    endcase
  end

  assign nl_ppn_full_c = mem_rdata_i[53:10];
  assign nl_ppn_hi_c   = (nl_ppn_full_c >> MAX_PPN) != 44'd0;
  assign nl_ppn_c      = mem_rdata_i[MAX_PPN+9:10];
  assign fsc_ppn_hi_c  = (mem_rdata_i[43:0] >> MAX_PPN) != 44'd0;
  assign fsc_mode_ok_c = (mem_rdata_i[63:60] == 4'd0) || (mem_rdata_i[63:60] == 4'd8) ||
                         (mem_rdata_i[63:60] == 4'd9) || (mem_rdata_i[63:60] == 4'd10);

  // Read-beat fault classification; earlier rows take priority.
  always_comb begin
    rd_fault_c = 1'b0;
    rd_cause_c = 12'd0;
    if (mem_err_i) begin
      rd_fault_c = 1'b1;
      rd_cause_c = CAUSE_LDF;
    end else if (level_q != 2'd0) begin
      if (!mem_rdata_i[0]) begin
        rd_fault_c = 1'b1;
        rd_cause_c = CAUSE_INV;
      end else if ((mem_rdata_i[9:1] != 9'd0) || (mem_rdata_i[63:54] != 10'd0) || nl_ppn_hi_c) begin
        rd_fault_c = 1'b1;
        rd_cause_c = CAUSE_MCFG;
      end
    end else if (!leaf_fsc_q) begin
      if (!mem_rdata_i[0]) begin
        rd_fault_c = 1'b1;
        rd_cause_c = CAUSE_INV;
      end else if ((mem_rdata_i[11:3] != 9'd0) || (mem_rdata_i[63:32] != 32'd0)) begin
        rd_fault_c = 1'b1;
        rd_cause_c = CAUSE_MCFG;
      end
    end else if (!fsc_mode_ok_c || fsc_ppn_hi_c) begin
      rd_fault_c = 1'b1;
      rd_cause_c = CAUSE_MCFG;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      level_q           <= 2'd0;
      leaf_fsc_q        <= 1'b0;
      ppn_q             <= '0;
      req_ready_o       <= 1'b1;
      rsp_valid_o       <= 1'b0;
      rsp_fault_o       <= 1'b0;
      rsp_cause_o       <= 12'd0;
      rsp_ens_o         <= 1'b0;
      rsp_sum_o         <= 1'b0;
      rsp_pscid_o       <= 20'd0;
      rsp_fsc_mode_o    <= 4'd0;
      rsp_fsc_ppn_o     <= '0;
      pdtc_lookup_o     <= 1'b0;
      pdtc_fill_o       <= 1'b0;
      pdtc_device_id_o  <= 24'd0;
      pdtc_process_id_o <= 20'd0;
      pdtc_ens_o        <= 1'b0;
      pdtc_sum_o        <= 1'b0;
      pdtc_pscid_o      <= 20'd0;
      pdtc_fsc_mode_o   <= 4'd0;
      pdtc_fsc_ppn_o    <= '0;
      mem_req_o         <= 1'b0;
      mem_addr_o        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid_i && req_ready_o) begin
            req_ready_o       <= 1'b0;
            pdtc_device_id_o  <= req_device_id_i;
            pdtc_process_id_o <= req_process_id_i;
            ppn_q             <= pdtp_ppn_i;
            level_q           <= pdtp_mode_i[1:0] - 2'd1;
            leaf_fsc_q        <= 1'b0;
            if (pid_ok_c) begin
              pdtc_lookup_o <= 1'b1;
              state         <= S_LOOKUP;
            end else begin
              rsp_valid_o    <= 1'b1;
              rsp_fault_o    <= 1'b1;
              rsp_cause_o    <= CAUSE_TTYP;
              rsp_ens_o      <= 1'b0;
              rsp_sum_o      <= 1'b0;
              rsp_pscid_o    <= 20'd0;
              rsp_fsc_mode_o <= 4'd0;
              rsp_fsc_ppn_o  <= '0;
              state          <= S_RSP;
            end
          end
        end
        S_LOOKUP: begin
          if (pdtc_lkup_fill_done_i) begin
            pdtc_lookup_o <= 1'b0;
            if (pdtc_hit_i) begin
              rsp_valid_o    <= 1'b1;
              rsp_fault_o    <= 1'b0;
              rsp_cause_o    <= 12'd0;
              rsp_ens_o      <= pdtc_ens_i;
              rsp_sum_o      <= pdtc_sum_i;
              rsp_pscid_o    <= pdtc_pscid_i;
              rsp_fsc_mode_o <= pdtc_fsc_mode_i;
              rsp_fsc_ppn_o  <= pdtc_fsc_ppn_i;
              state          <= S_RSP;
            end else begin
              mem_addr_o <= walk_addr(ppn_q, level_q, pdtc_process_id_o);
              mem_req_o  <= 1'b1;
              state      <= S_RD_REQ;
            end
          end
        end
        S_RD_REQ: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            state     <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (mem_rvalid_i) begin
            if (rd_fault_c) begin
              rsp_valid_o    <= 1'b1;
              rsp_fault_o    <= 1'b1;
              rsp_cause_o    <= rd_cause_c;
              rsp_ens_o      <= 1'b0;
              rsp_sum_o      <= 1'b0;
              rsp_pscid_o    <= 20'd0;
              rsp_fsc_mode_o <= 4'd0;
              rsp_fsc_ppn_o  <= '0;
              state          <= S_RSP;
            end else if (level_q != 2'd0) begin
              ppn_q      <= nl_ppn_c;
              level_q    <= level_q - 2'd1;
              mem_addr_o <= walk_addr(nl_ppn_c, level_q - 2'd1, pdtc_process_id_o);
              mem_req_o  <= 1'b1;
              state      <= S_RD_REQ;
            end else if (!leaf_fsc_q) begin
              // PC.ta accepted; the fsc doubleword follows it.
              pdtc_ens_o   <= mem_rdata_i[1];
              pdtc_sum_o   <= mem_rdata_i[2];
              pdtc_pscid_o <= mem_rdata_i[31:12];
              leaf_fsc_q   <= 1'b1;
              mem_addr_o   <= mem_addr_o + MAX_PA'(8);
              mem_req_o    <= 1'b1;
              state        <= S_RD_REQ;
            end else begin
              pdtc_fsc_mode_o <= mem_rdata_i[63:60];
              pdtc_fsc_ppn_o  <= mem_rdata_i[MAX_PPN-1:0];
              pdtc_fill_o     <= 1'b1;
              state           <= S_FILL;
            end
          end
        end
        S_FILL: begin
          if (pdtc_lkup_fill_done_i) begin
            pdtc_fill_o    <= 1'b0;
            rsp_valid_o    <= 1'b1;
            rsp_fault_o    <= 1'b0;
            rsp_cause_o    <= 12'd0;
            rsp_ens_o      <= pdtc_ens_o;
            rsp_sum_o      <= pdtc_sum_o;
            rsp_pscid_o    <= pdtc_pscid_o;
            rsp_fsc_mode_o <= pdtc_fsc_mode_o;
            rsp_fsc_ppn_o  <= pdtc_fsc_ppn_o;
            state          <= S_RSP;
          end
        end
        S_RSP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
